// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - framed serial-to-parallel operand loader for the adder
// Two operands arrive LSB first; a full frame is held with valid until the adder takes it.
module operand_loader #(
   parameter int D_N = 32
) (
   input  logic           w_clk,
   input  logic           w_rst,
   input  logic           w_start,
   input  logic           w_bit_valid,
   input  logic           w_a,
   input  logic           w_b,
   input  logic           w_ready,
   output logic [D_N-1:0] w_opa,
   output logic [D_N-1:0] w_opb,
   output logic           w_valid,
   output logic           w_busy,
   output logic           w_drop
);

   localparam int CW = $clog2(D_N);
   localparam logic [CW-1:0] LAST_BIT = CW'(D_N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state;
   logic [D_N-1:0]  r_a;
   logic [D_N-1:0]  r_b;
   logic [CW-1:0]   r_cnt;

   assign w_opa = r_a;
   assign w_opb = r_b;

   // w_valid/w_busy are written alongside every state change so they stay pure flops.
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state   <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         w_valid <= 1'b0;
         w_busy  <= 1'b0;
         w_drop  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (w_start) begin
                  r_a    <= '0;
                  r_b    <= '0;
                  r_cnt  <= '0;
                  w_drop <= 1'b0;
                  w_busy <= 1'b1;
                  state  <= SHIFT;
               end
            end

            SHIFT: begin
               if (w_start) begin
                  r_a   <= '0;
                  r_b   <= '0;
                  r_cnt <= '0;
               end else if (w_bit_valid) begin
                  r_a <= {w_a, r_a[D_N-1:1]};
                  r_b <= {w_b, r_b[D_N-1:1]};
                  if (r_cnt == LAST_BIT) begin
                     r_cnt   <= '0;
                     w_valid <= 1'b1;
                     state   <= HOLD;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
            end

            HOLD: begin
               if (w_bit_valid) begin
                  w_drop <= 1'b1;
               end
               // A start coinciding with the transfer opens the next frame on the same edge.
               if (w_ready) begin
                  w_valid <= 1'b0;
                  if (w_start) begin
                     r_a    <= '0;
                     r_b    <= '0;
                     r_cnt  <= '0;
                     w_drop <= 1'b0;
                     state  <= SHIFT;
                  end else begin
                     w_busy <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end

            default: begin
               w_valid <= 1'b0;
               w_busy  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - scoreboard bench for operand_loader
// Stimulus pushes expected operand pairs; a negedge monitor compares whenever w_valid is up.
module tb_operand_loader;

   localparam int D_N = 32;

   logic           w_clk = 1'b0;
   logic           w_rst = 1'b1;
   logic           w_start = 1'b0;
   logic           w_bit_valid = 1'b0;
   logic           w_a = 1'b0;
   logic           w_b = 1'b0;
   logic           w_ready = 1'b0;
   logic [D_N-1:0] w_opa;
   logic [D_N-1:0] w_opb;
   logic           w_valid;
   logic           w_busy;
   logic           w_drop;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_no   = 0;
   logic [63:0] exp_q[$];

   operand_loader #(.D_N(D_N)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .w_start(w_start), .w_bit_valid(w_bit_valid),
      .w_a(w_a), .w_b(w_b), .w_ready(w_ready), .w_opa(w_opa), .w_opb(w_opb),
      .w_valid(w_valid), .w_busy(w_busy), .w_drop(w_drop)
   );

   always #5 w_clk = ~w_clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, got, exp, cyc_no);
   endtask

   task automatic cyc();
      @(posedge w_clk);
      #1;
      cyc_no++;
   endtask

   // Scoreboard monitor: held operands must equal the oldest outstanding frame.
   always @(negedge w_clk) begin
      if (!w_rst && w_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'(w_valid), 64'd0);
         end else begin
            check("mon_opa", 64'(w_opa), 64'(exp_q[0][63:32]));
            check("mon_opb", 64'(w_opb), 64'(exp_q[0][31:0]));
            if (w_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Reference: value is the sum of bit[i]*2^i over the order bits were sent.
   function automatic logic [31:0] bits_to_word(input logic q[$]);
      logic [31:0] v = 0;
      for (int i = 0; i < q.size(); i++) if (q[i]) v = v + (32'd1 << i);
      return v;
   endfunction

   // gap_mode: 0 none, 1 a gap before every bit, 2 random gaps
   task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                             input int gap_mode, output int ngaps);
      logic [31:0] av, bv;
      av = a; bv = b; ngaps = 0;
      for (int i = 0; i < D_N; i++) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            w_bit_valid = 1'b0; w_a = 1'($urandom); w_b = 1'($urandom);
            cyc(); ngaps++;
         end
         w_bit_valid = 1'b1; w_a = av[i]; w_b = bv[i];
         if (i == D_N - 1) check("valid_before_last", 64'(w_valid), 64'd0);
         cyc();
      end
      w_bit_valid = 1'b0;
   endtask

   task automatic start_frame(output int st);
      st = cyc_no;
      w_start = 1'b1; cyc(); w_start = 1'b0;
   endtask

   task automatic release_hold();
      w_ready = 1'b1; cyc(); w_ready = 1'b0;
      check("valid_after_xfer", 64'(w_valid), 64'd0);
      check("busy_after_xfer", 64'(w_busy), 64'd0);
   endtask

   initial begin
      int st, ng;
      logic qa[$];
      logic qb[$];
      logic [31:0] ea, eb;
      logic in_hold;

      repeat (3) cyc();
      w_rst = 1'b0;
      check("rst_opa", 64'(w_opa), 64'd0);
      check("rst_opb", 64'(w_opb), 64'd0);
      check("rst_flags", {61'd0, w_valid, w_busy, w_drop}, 64'd0);

      // Plain frame, no gaps
      exp_q.push_back({32'd45, 32'd34});
      start_frame(st);
      check("busy_after_start", 64'(w_busy), 64'd1);
      send_frame(32'd45, 32'd34, 0, ng);
      check("latency_plain", 64'(cyc_no - st), 64'(D_N + 1));
      check("valid_plain", 64'(w_valid), 64'd1);
      check("busy_plain", 64'(w_busy), 64'd1);
      repeat (2) cyc();
      release_hold();

      // Gap before every bit
      exp_q.push_back({32'd45, 32'd34});
      start_frame(st);
      send_frame(32'd45, 32'd34, 1, ng);
      check("latency_gaps", 64'(cyc_no - st), 64'(D_N + 1 + ng));
      check("valid_gaps", 64'(w_valid), 64'd1);
      release_hold();

      // Aborted frame followed by restart
      start_frame(st);
      repeat (10) begin
         w_bit_valid = 1'b1; w_a = 1'b1; w_b = 1'b1; cyc();
      end
      w_bit_valid = 1'b0;
      exp_q.push_back({32'd7, 32'd1});
      w_start = 1'b1; w_bit_valid = 1'b1; w_a = 1'b1; w_b = 1'b1;
      st = cyc_no; cyc(); w_start = 1'b0;
      check("drop_on_restart", 64'(w_drop), 64'd0);
      send_frame(32'd7, 32'd1, 0, ng);
      check("latency_restart", 64'(cyc_no - st), 64'(D_N + 1));
      check("restart_opa", 64'(w_opa), 64'd7);

      // Bits during HOLD are dropped, operands stay put
      repeat (5) begin
         w_bit_valid = 1'b1; w_a = 1'($urandom); w_b = 1'($urandom); cyc();
      end
      w_bit_valid = 1'b0;
      check("drop_set", 64'(w_drop), 64'd1);
      check("hold_opa", 64'(w_opa), 64'd7);
      check("hold_opb", 64'(w_opb), 64'd1);
      release_hold();
      check("drop_sticky", 64'(w_drop), 64'd1);
      start_frame(st);
      check("drop_cleared", 64'(w_drop), 64'd0);
      exp_q.push_back({32'h1234_5678, 32'h8765_4321});
      send_frame(32'h1234_5678, 32'h8765_4321, 0, ng);

      // Back-to-back transfer and start
      st = cyc_no;
      w_ready = 1'b1; w_start = 1'b1; cyc(); w_ready = 1'b0; w_start = 1'b0;
      check("b2b_busy", 64'(w_busy), 64'd1);
      check("b2b_valid", 64'(w_valid), 64'd0);
      exp_q.push_back({32'hFFFF_FFFF, 32'd1});
      send_frame(32'hFFFF_FFFF, 32'd1, 0, ng);
      check("latency_b2b", 64'(cyc_no - st), 64'(D_N + 1));
      check("b2b_sum", 64'(32'(w_opa + w_opb)), 64'd0);
      release_hold();

      // Reset mid-frame, then bits without a start are ignored
      start_frame(st);
      repeat (20) begin
         w_bit_valid = 1'b1; w_a = 1'b1; w_b = 1'b1; cyc();
      end
      w_rst = 1'b1; cyc(); w_rst = 1'b0;
      check("midrst_ab", {w_opa, w_opb}, 64'd0);
      check("midrst_flags", {61'd0, w_valid, w_busy, w_drop}, 64'd0);
      repeat (40) begin
         w_bit_valid = 1'b1; w_a = 1'($urandom); w_b = 1'($urandom); cyc();
      end
      w_bit_valid = 1'b0;
      check("idle_ab", {w_opa, w_opb}, 64'd0);
      check("idle_flags", {61'd0, w_valid, w_busy, w_drop}, 64'd0);

      // Randomized frames with gaps, restarts and random backpressure
      in_hold = 1'b0;
      for (int f = 0; f < 25; f++) begin
         qa.delete(); qb.delete();
         for (int i = 0; i < D_N; i++) begin
            qa.push_back(1'($urandom)); qb.push_back(1'($urandom));
         end
         ea = bits_to_word(qa); eb = bits_to_word(qb);
         if (in_hold && $urandom_range(0, 1) == 1) begin
            st = cyc_no;
            w_ready = 1'b1; w_start = 1'b1; cyc(); w_ready = 1'b0; w_start = 1'b0;
         end else begin
            if (in_hold) release_hold();
            repeat ($urandom_range(0, 2)) cyc();
            start_frame(st);
         end
         exp_q.push_back({ea, eb});
         send_frame(ea, eb, 2, ng);
         check("rnd_latency", 64'(cyc_no - st), 64'(D_N + 1 + ng));
         check("rnd_valid", 64'(w_valid), 64'd1);
         repeat ($urandom_range(0, 3)) cyc();
         in_hold = 1'b1;
      end
      release_hold();

      repeat (3) cyc();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
